// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset sequencer running on the 50 MHz reference clock.
// Pulses the PLL reset, qualifies the synchronized lock flag, and releases the
// active-low system reset only after lock has been continuously stable.
// Optional feature macro: PLL_RESET_CTRL_TIMEOUT_EN (WAIT_LOCK timeout + retry).
module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ok,
  output logic [7:0] retry_count
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;

  // Shared counter must be able to reach every terminal count.
  if ((64'd1 << CNT_W) < 64'(MAX_CNT)) begin : g_cnt_w_too_small
    $error("pll_reset_ctrl: CNT_W too small for configured cycle counts");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sync_q, locked_s;
  logic             to_hit;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

`ifdef PLL_RESET_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic retry_inc;

  assign to_hit    = (cnt == TO_LAST);
  // Lock arriving in the same cycle as the timeout takes priority.
  assign retry_inc = (state == WAIT_LOCK) && !locked_s && to_hit;

  // Saturating count of lock-timeout retries; cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retry_count <= 8'd0;
    else if (retry_inc && (retry_count != 8'hFF))
      retry_count <= retry_count + 8'd1;
  end
`else
  assign to_hit      = 1'b0;
  assign retry_count = 8'd0;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      PLL_RESET: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s)    state_nxt = STABLE;
        else if (to_hit) state_nxt = PLL_RESET;
      end
      STABLE: begin
        if (!locked_s)                 state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST)   state_nxt = RUN;
      end
      RUN:       if (!locked_s) state_nxt = PLL_RESET;
      default:   state_nxt = PLL_RESET;
    endcase
  end

  // State register and shared counter; counter clears on every transition and
  // holds at all-ones rather than wrapping in the open-ended states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PLL_RESET;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 1'b1;
    end
  end

  // Outputs decoded from next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      pll_ok    <= 1'b0;
    end else begin
      pll_rst   <= (state_nxt == PLL_RESET);
      sys_rst_n <= (state_nxt == RUN);
      pll_ok    <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed stimulus, literal timing checks, and a
// per-cycle comparison against a counter-based behavioural model.
module tb_pll_reset_ctrl;
  localparam int RST = 4;
  localparam int LS  = 8;
  localparam int TO  = 32;
  localparam int W   = 6;
`ifdef PLL_RESET_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst_n, pll_ok;
  logic [7:0] retry_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pll_reset_ctrl #(
    .RST_CYCLES(RST), .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT_CYCLES(TO), .CNT_W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .pll_ok(pll_ok),
    .retry_count(retry_count)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: lock seen two edges late; reset pulse as a countdown,
  // lock qualification as a run-length of consecutive locked cycles.
  logic m_s1 = 0, m_s2 = 0;
  int   m_rst_left = RST;
  bit   m_run = 0;
  int   m_stab = -1;
  int   m_wait = 0;
  int   m_retry = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_rst_left = RST; m_run = 0;
      m_stab = -1; m_wait = 0; m_retry = 0;
    end else begin
      if (m_rst_left > 0) begin
        m_rst_left--;
        if (m_rst_left == 0) m_wait = 0;
      end else if (m_run) begin
        if (!m_s2) begin m_run = 0; m_rst_left = RST; end
      end else if (m_stab >= 0) begin
        if (!m_s2) begin m_stab = -1; m_wait = 0; end
        else if (m_stab == LS - 1) begin m_run = 1; m_stab = -1; end
        else m_stab++;
      end else begin
        if (m_s2) m_stab = 0;
        else if (TO_EN && m_wait == TO - 1) begin
          m_rst_left = RST;
          if (m_retry < 255) m_retry++;
        end else m_wait++;
      end
      m_s2 = m_s1;
      m_s1 = pll_locked;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("mdl_pll_rst",   pll_rst,     (m_rst_left > 0));
    chk("mdl_sys_rst_n", sys_rst_n,   m_run);
    chk("mdl_pll_ok",    pll_ok,      m_run);
    chk("mdl_retry",     retry_count, m_retry);
  end

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic set_lock(input logic v);
    @(negedge clk); pll_locked = v;
  endtask

  // Bounded wait for pll_rst (sel=0) or sys_rst_n (sel=1) to reach val.
  task automatic wait_sig(input int sel, input logic val, input int max, input string name, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < max; i++) begin
      edge1();
      s = (sel == 0) ? pll_rst : sys_rst_n;
      if (s == val) begin at = cyc; break; end
    end
    if (at < 0) chk(name, 0, 1);
  endtask

  int  t0, t1, t2;
  bit  seen;

  initial begin
    // Power-up
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_pll_ok", pll_ok, 0);
    chk("rst_retry", retry_count, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= RST; k++) begin
      edge1();
      chk("pwr_pll_rst_width", pll_rst, (k < RST));
    end
    repeat (9) edge1();
    set_lock(1'b1);
    for (int k = 0; k <= 10; k++) begin
      edge1();
      chk("pwr_sys_rst_n", sys_rst_n, (k == 10));
    end
    chk("pwr_pll_ok", pll_ok, 1);

    // Lock loss in RUN: 3-edge latency, 4-cycle PLL pulse
    set_lock(1'b0);
    for (int k = 0; k <= 6; k++) begin
      edge1();
      chk("loss_sys_rst_n", sys_rst_n, (k < 2));
      chk("loss_pll_rst", pll_rst, (k >= 2 && k <= 5));
    end

    // Relock, then glitch during STABLE
    set_lock(1'b1);
    seen = 0;
    for (int k = 0; k <= 6; k++) begin
      edge1();
      if (pll_rst) seen = 1;
    end
    set_lock(1'b0);
    for (int k = 0; k < 3; k++) begin
      edge1();
      if (pll_rst) seen = 1;
    end
    set_lock(1'b1);
    for (int k = 0; k <= 10; k++) begin
      edge1();
      if (pll_rst) seen = 1;
      chk("glitch_sys_rst_n", sys_rst_n, (k == 10));
    end
    chk("glitch_no_pll_pulse", seen, 0);

`ifdef PLL_RESET_CTRL_TIMEOUT_EN
    // Timeout and retry
    set_lock(1'b0);
    wait_sig(0, 1'b1, 10, "to_first_pulse", t0);
    for (int i = 1; i <= 3; i++) begin
      wait_sig(0, 1'b0, 10, "to_pulse_end", t1);
      chk("to_pulse_width", t1 - t0, RST);
      wait_sig(0, 1'b1, 60, "to_next_pulse", t2);
      chk("to_period", t2 - t0, RST + TO);
      chk("to_retry_count", retry_count, i);
      t0 = t2;
    end
    repeat (300 * (RST + TO)) edge1();
    chk("to_retry_sat", retry_count, 255);
    set_lock(1'b1);
    wait_sig(1, 1'b1, 100, "to_relock_run", t0);
`else
    // No timeout: one pulse, then indefinite wait
    set_lock(1'b0);
    wait_sig(0, 1'b1, 10, "nto_pulse", t0);
    wait_sig(0, 1'b0, 10, "nto_pulse_end", t1);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      edge1();
      if (pll_rst) seen = 1;
    end
    chk("nto_no_second_pulse", seen, 0);
    chk("nto_retry_zero", retry_count, 0);
    set_lock(1'b1);
    for (int k = 0; k <= 10; k++) begin
      edge1();
      chk("nto_sys_rst_n", sys_rst_n, (k == 10));
    end
`endif

    // Asynchronous reset mid-RUN
    chk("async_pre_run", sys_rst_n, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys_rst_n", sys_rst_n, 0);
    chk("async_pll_ok", pll_ok, 0);
    chk("async_retry", retry_count, 0);
    rst_n = 1'b1;
    wait_sig(1, 1'b1, 40, "async_resequence", t0);
    repeat (2) edge1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit.
  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
